task_batch_buffer: RTL
======================

// Module: task_batch_buffer
// PURPOSE
//  Holds one task batch fetched from host memory for a single PE Array; mirror of the result path.
//  Issues one line read request per 512b line, then writes the out-of-order read responses into a BRAM.
//  Once all lines are present it presents the batch to the PE Array as 32b words at random addresses.
//  Sits between the host read-request arbiter/response router and one PE Array's task input.
// PARAMETERS
//  TBB_WR_ADDR_WIDTH  8    line index width; NUM_LINES = 2**8 = 256
//  TBB_WR_DATA_WIDTH  512  host line width
//  TBB_RD_ADDR_WIDTH  12   PE word address width; must equal TBB_WR_ADDR_WIDTH+4
//  TBB_RD_DATA_WIDTH  32   PE word width; 16 words per line
// PORTS
//  clk         in   1    core clock
//  reset_n     in   1    synchronous, active-low reset
//  batch_start in   1    pulse: begin fetching a new batch (honoured only in IDLE)
//  ReqValid    out  1    line read request valid
//  ReqLineIdx  out  8    line index being requested
//  ReqAck      in   1    arbiter accepted current request this cycle
//  RspValid    in   1    read response valid (no back-pressure)
//  RspLineIdx  in   8    line index of response
//  RspData     in   512  response line
//  RdAddr      in   12   PE word address: [11:4] line, [3:0] word in line
//  RdDout      out  32   PE word, 2-cycle latency from RdAddr
//  batch_release in 1    pulse: PE finished with batch (honoured only in FULL)
//  Full        out  1    batch complete and readable (state FULL)
//  Empty       out  1    state IDLE
//  RspErr      out  1    sticky: response received outside REQ/WAIT
// BEHAVIOUR
//  Reset: state IDLE, req_idx=0, rsp_cnt=0, ReqValid=0, ReqLineIdx=0, Full=0, Empty=1, RspErr=0,
//   RdDout=0. BRAM contents are not cleared.
//  FSM, one-hot, 4 states: IDLE, REQ, WAIT, FULL.
//  IDLE -> REQ on batch_start; req_idx<=0, rsp_cnt<=0.
//  REQ: ReqValid=1, ReqLineIdx=req_idx. On ReqAck, req_idx++. ReqAck with req_idx==255 -> WAIT.
//   ReqValid stays high until acked; ReqLineIdx is stable while unacked.
//  WAIT: ReqValid=0; -> FULL on the cycle rsp_cnt reaches 256.
//  Responses are accepted in REQ and WAIT, in any order. Each RspValid writes RspData at RspLineIdx
//   (1-cycle registered write path: we/waddr/din flopped) and increments rsp_cnt (9 bits).
//  Last response arriving while still in REQ (impossible unless arbiter misbehaves) -> stay REQ; FSM
//   moves REQ->WAIT->FULL normally. rsp_cnt saturates at 256.
//  FULL -> IDLE on batch_release; the next batch_start is accepted no earlier than the following cycle.
//  batch_start outside IDLE and batch_release outside FULL are ignored.
//  RspValid in IDLE or FULL: data is discarded, no BRAM write, RspErr<=1 (cleared only by reset).
//  Full=1 is asserted 1 cycle after the last BRAM write is issued, so the final line is readable once
//   Full is seen.
//  Word order within a line: word k (RdAddr[3:0]=k) = RspData[511-32k -: 32]. Word 0 is the MSW,
//   matching the result-path packing.
//  Read path: raddr=RdAddr[11:4] into BRAM (1-cycle registered dout). RdAddr[3:0] is delayed 1 cycle
//   and selects the word. The mux output is registered, so RdDout is valid 2 cycles after RdAddr.
//   The read path is pipelined: a new address every cycle.
//  Reads are legal in any state; data is meaningful only in FULL. RdDout holds its value when no
//   new address is presented (pure pipeline, continuously updated).
//  Reset mid-fetch: returns to IDLE immediately. Stale responses arriving afterwards set RspErr.
// STRUCTURE
//  tbb_pkg: state localparams (IDLE/REQ/WAIT/FULL), NUM_LINES, WORDS_PER_LINE=16, word-select helper.
//  Sub-module: nlb_gram_sdp (BUS_SIZE_ADDR=8, BUS_SIZE_DATA=512, GRAM_MODE=1) as the line store.
//  No other hierarchy; FSM, counters and word mux are local.
// TESTING
//  1 Full fetch, ReqAck every cycle, responses in order, line L = {16{L,word k}} patterns ->
//    256 requests with idx 0..255, Full rises 1 cycle after 256th write, RdAddr=0x013 returns line 1
//    word 3 after 2 cycles.
//  2 Responses in reverse order (255..0) with random gaps, ReqAck throttled to 1-in-3 ->
//    ReqLineIdx held stable while unacked, Full only after all 256 responses, every word reads back
//    correctly.
//  3 Back-to-back reads 0x000..0xFFF, one per cycle in FULL -> RdDout stream matches golden with
//    fixed 2-cycle lag, no bubbles.
//  4 batch_release in FULL, then batch_start next cycle -> Empty=1 for >=1 cycle, fetch restarts
//    at idx 0, rsp_cnt=0; batch_start during REQ ignored.
//  5 RspValid in IDLE with idx 5 -> RspErr=1, line 5 unchanged; RspErr persists through the next
//    batch until reset.
//  6 Assert reset_n=0 for 1 cycle after 100 acks/60 responses -> IDLE, ReqValid=0, Full=0; new fetch
//    completes normally.

Source files
------------

// File: rtl/tbb_pkg.sv
// Shared constants, one-hot state encoding and the line-to-word select helper
// for the task batch buffer.
package tbb_pkg;

  localparam int TBB_WR_ADDR_WIDTH = 8;
  localparam int TBB_WR_DATA_WIDTH = 512;
  localparam int TBB_RD_ADDR_WIDTH = TBB_WR_ADDR_WIDTH + 4;
  localparam int TBB_RD_DATA_WIDTH = 32;

  localparam int NUM_LINES      = 2 ** TBB_WR_ADDR_WIDTH;
  localparam int WORDS_PER_LINE = TBB_WR_DATA_WIDTH / TBB_RD_DATA_WIDTH;
  localparam int WORD_SEL_WIDTH = $clog2(WORDS_PER_LINE);
  localparam int CNT_WIDTH      = TBB_WR_ADDR_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0]         CNT_FULL = CNT_WIDTH'(NUM_LINES);
  localparam logic [TBB_WR_ADDR_WIDTH-1:0] LAST_IDX = TBB_WR_ADDR_WIDTH'(NUM_LINES - 1);

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_REQ  = 4'b0010;
  localparam logic [3:0] ST_WAIT = 4'b0100;
  localparam logic [3:0] ST_FULL = 4'b1000;

  typedef enum logic [3:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    FULL = ST_FULL
  } tbb_state_e;

  // Word 0 is the most significant word of a line, matching the result-path packing.
  function automatic logic [TBB_RD_DATA_WIDTH-1:0] tbb_word_sel(
    input logic [TBB_WR_DATA_WIDTH-1:0] line,
    input logic [WORD_SEL_WIDTH-1:0]    k
  );
    return line[(TBB_WR_DATA_WIDTH - 1) - TBB_RD_DATA_WIDTH * int'(k) -: TBB_RD_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/task_batch_buffer_if.sv
// Host request/response, PE read port and batch control signals of one task batch buffer.
interface task_batch_buffer_if;
  import tbb_pkg::*;

  // Requests: ReqValid stays high with ReqLineIdx stable until ReqAck; a request
  // transfers on a cycle where ReqValid && ReqAck. Responses have no ready: every
  // RspValid cycle carries one line. batch_start/batch_release are single-cycle pulses.
  logic                         batch_start;
  logic                         batch_release;
  logic                         ReqValid;
  logic [TBB_WR_ADDR_WIDTH-1:0] ReqLineIdx;
  logic                         ReqAck;
  logic                         RspValid;
  logic [TBB_WR_ADDR_WIDTH-1:0] RspLineIdx;
  logic [TBB_WR_DATA_WIDTH-1:0] RspData;
  logic [TBB_RD_ADDR_WIDTH-1:0] RdAddr;
  logic [TBB_RD_DATA_WIDTH-1:0] RdDout;
  logic                         Full;
  logic                         Empty;
  logic                         RspErr;

  modport master (
    input  batch_start, batch_release, ReqAck, RspValid, RspLineIdx, RspData, RdAddr,
    output ReqValid, ReqLineIdx, RdDout, Full, Empty, RspErr
  );

  modport slave (
    output batch_start, batch_release, ReqAck, RspValid, RspLineIdx, RspData, RdAddr,
    input  ReqValid, ReqLineIdx, RdDout, Full, Empty, RspErr
  );

endinterface

// File: rtl/nlb_gram_sdp.sv
// Simple dual-port RAM: one write port, one read port; GRAM_MODE=1 registers the read data.
module nlb_gram_sdp #(
  parameter int BUS_SIZE_ADDR = 8,
  parameter int BUS_SIZE_DATA = 512,
  parameter int GRAM_MODE     = 1
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [BUS_SIZE_ADDR-1:0] waddr_i,
  input  logic [BUS_SIZE_DATA-1:0] din_i,
  input  logic [BUS_SIZE_ADDR-1:0] raddr_i,
  output logic [BUS_SIZE_DATA-1:0] dout_o
);

  logic [BUS_SIZE_DATA-1:0] mem_q [2**BUS_SIZE_ADDR];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= din_i;
    end
  end

  generate
    if (GRAM_MODE == 1) begin : g_reg_out
      always_ff @(posedge clk) begin
        dout_o <= mem_q[raddr_i];
      end
    end else begin : g_comb_out
      assign dout_o = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/task_batch_buffer.sv
// Fetches one 256-line task batch from host memory into a line store and serves it
// to a PE Array as 32b words with a 2-cycle read pipeline.
module task_batch_buffer
  import tbb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  task_batch_buffer_if.master  bus,
  output tbb_state_e           state_o
);

  tbb_state_e                   state_q, state_d;
  logic [TBB_WR_ADDR_WIDTH-1:0] req_idx_q, req_idx_d;
  logic [CNT_WIDTH-1:0]         rsp_cnt_q, rsp_cnt_d;
  logic                         rsp_err_q, rsp_err_d;
  logic                         rsp_accept;

  logic                         wr_en_q;
  logic [TBB_WR_ADDR_WIDTH-1:0] wr_addr_q;
  logic [TBB_WR_DATA_WIDTH-1:0] wr_data_q;

  logic [WORD_SEL_WIDTH-1:0]    word_sel_q;
  logic [TBB_WR_DATA_WIDTH-1:0] line_dout;
  logic [TBB_RD_DATA_WIDTH-1:0] rd_dout_q;

  assign rsp_accept = bus.RspValid && ((state_q == REQ) || (state_q == WAIT));

  always_comb begin
    state_d   = state_q;
    req_idx_d = req_idx_q;
    rsp_cnt_d = rsp_cnt_q;
    rsp_err_d = rsp_err_q || (bus.RspValid && !rsp_accept);

    // The count saturates so a misbehaving arbiter cannot wrap it back below full.
    if (rsp_accept && (rsp_cnt_q != CNT_FULL)) begin
      rsp_cnt_d = rsp_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.batch_start) begin
          state_d   = REQ;
          req_idx_d = '0;
          rsp_cnt_d = '0;
        end
      end
      REQ: begin
        if (bus.ReqAck) begin
          req_idx_d = req_idx_q + 1'b1;
          if (req_idx_q == LAST_IDX) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (rsp_cnt_q == CNT_FULL) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.batch_release) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_idx_q <= '0;
      rsp_cnt_q <= '0;
      rsp_err_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_dout_q <= '0;
    end else begin
      state_q   <= state_d;
      req_idx_q <= req_idx_d;
      rsp_cnt_q <= rsp_cnt_d;
      rsp_err_q <= rsp_err_d;
      wr_en_q   <= rsp_accept;
      rd_dout_q <= tbb_word_sel(line_dout, word_sel_q);
    end
  end

  // Write data and read word select need no reset: they only matter when qualified.
  always_ff @(posedge clk) begin
    wr_addr_q  <= bus.RspLineIdx;
    wr_data_q  <= bus.RspData;
    word_sel_q <= bus.RdAddr[WORD_SEL_WIDTH-1:0];
  end

  nlb_gram_sdp #(
    .BUS_SIZE_ADDR (TBB_WR_ADDR_WIDTH),
    .BUS_SIZE_DATA (TBB_WR_DATA_WIDTH),
    .GRAM_MODE     (1)
  ) u_line_store (
    .clk     (clk),
    .we_i    (wr_en_q),
    .waddr_i (wr_addr_q),
    .din_i   (wr_data_q),
    .raddr_i (bus.RdAddr[TBB_RD_ADDR_WIDTH-1:WORD_SEL_WIDTH]),
    .dout_o  (line_dout)
  );

  assign bus.ReqValid   = (state_q == REQ);
  assign bus.ReqLineIdx = req_idx_q;
  assign bus.RdDout     = rd_dout_q;
  assign bus.Full       = (state_q == FULL);
  assign bus.Empty      = (state_q == IDLE);
  assign bus.RspErr     = rsp_err_q;
  assign state_o        = state_q;

endmodule
